ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port ram_top.
- Accepts one read or write command at a time from either requester using a valid/ready handshake.
- Drives ram_top's we/adr/din and returns read data, or a write acknowledgement, to the requester that issued the command.
- Sits between the datapath clients and ram_top, whose read is synchronous: dout is valid one cycle after adr is applied.

Parameters:
- N, 4, address width (RAM depth 2^N words).
- M, 32, data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_we  in  1  1 = write, 0 = read.
- req0_adr  in  N  command address.
- req0_din  in  M  write data.
- rsp0_valid  out  1  one-cycle response pulse to requester 0.
- rsp0_dout  out  M  read data (0 for write acks).
- req1_valid, req1_ready, req1_we, req1_adr, req1_din, rsp1_valid, rsp1_dout: same as port 0, for requester 1.
- ram_we  out  1  to ram_top.we.
- ram_adr  out  N  to ram_top.adr.
- ram_din  out  M  to ram_top.din.
- ram_dout  in  M  from ram_top.dout.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE, last_grant=1.
  - ram_we=0, ram_adr=0, ram_din=0.
  - rsp0/1_valid=0, rsp0/1_dout=0, busy=0.
- Arbitration, IDLE only:
  - Exactly one valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - reqX_ready = (state==IDLE) && grant==X. Combinational; at most one ready high per cycle.
  - Accept = valid && ready at a rising edge. On accept, register we/adr/din, the requester id and last_grant=id.
- Handshake rules:
  - A requester holds valid/we/adr/din stable until ready.
  - Responses have no backpressure; rsp_valid is a single-cycle pulse.
  - Ready is 0 in every state except IDLE.
- FSM (accept at edge ending cycle T):
  - ACCESS (T+1): ram_we=cmd_we, ram_adr/ram_din = registered command. RAM writes or samples the address at the end of T+1. Next state: write -> RESP, read -> RDWAIT.
  - RDWAIT (T+2, reads only): ram_we=0. ram_dout is captured into the response register at the end of T+2. Next state: RESP.
  - RESP: rspX_valid=1 for the owning requester only. rspX_dout = captured data for reads, 0 for writes. ram_we=0. Next state: IDLE.
  - IDLE: ram_we=0. ram_adr/ram_din hold their last values.
- Latency and throughput:
  - Write: rsp_valid in T+2; next accept possible at the edge ending T+3.
  - Read: rsp_valid in T+3, data = RAM contents at ram_adr as of T+1; next accept possible at the edge ending T+4.
- Write-then-read of the same address by either requester returns the new data. Commands are strictly serialized, so no hazard logic is needed.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1… starting with 0 after reset.
- Starvation: none; a waiting requester is served after at most one command of the other.
- Reset mid-operation: rst forces ram_we=0 and rsp*_valid=0 immediately (asynchronous). The in-flight command is dropped with no response; state returns to IDLE.
- Wrap-around: addresses 0 and 2^N-1 are handled identically; there is no address arithmetic.
- Deasserting valid without a handshake is illegal. Behaviour is undefined but must not corrupt the FSM.

Test Plan:
1. Port 0 writes adr=1, din=0x0000000A, then reads adr=1 -> ram_we high for exactly one cycle in T+1; write rsp0_valid in T+2 with rsp0_dout=0; read rsp0_dout=0x0000000A in T+3; rsp1_valid never high.
2. Port 1 writes adr=0xF, din=0xFA12, then port 0 reads adr=0xF -> rsp0_dout=0x0000FA12.
3. Both ports valid together for 4 commands each, port 0 writing adr=0/din=0xFFFF and port 1 writing adr=8/din=0xFFFFFFFF -> grants alternate 0,1,0,1…; readback of adr 0 = 0x0000FFFF and adr 8 = 0xFFFFFFFF.
4. Port 0 alone issues back-to-back reads -> one accept every 4 cycles, ready low while busy=1.
5. Write adr=1/din=0xF, then assert rst during ACCESS of a read to adr=1 -> ram_we and rsp*_valid drop immediately; no response; after release, busy=0 and req0_ready=1 with port 0 valid; a re-read of adr=1 returns 0xF, proving the write completed before reset.
6. Write to adr=1 followed by a read of adr=1 from the other requester -> returns the new value.

Source files
------------

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer for two requesters sharing a single-port,
// synchronous-read RAM. One command in flight; response pulsed back to its owner.
module ram_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned M = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic         req0_we,
  input  logic [N-1:0] req0_adr,
  input  logic [M-1:0] req0_din,
  output logic         rsp0_valid,
  output logic [M-1:0] rsp0_dout,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic         req1_we,
  input  logic [N-1:0] req1_adr,
  input  logic [M-1:0] req1_din,
  output logic         rsp1_valid,
  output logic [M-1:0] rsp1_dout,
  output logic         ram_we,
  output logic [N-1:0] ram_adr,
  output logic [M-1:0] ram_din,
  input  logic [M-1:0] ram_dout,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic         last_grant_q, last_grant_d;
  logic         owner_q, owner_d;
  logic         grant_c;
  logic         accept_c;
  logic         ram_we_d;
  logic [N-1:0] ram_adr_d;
  logic [M-1:0] ram_din_d;
  logic         rsp0_valid_d, rsp1_valid_d;
  logic [M-1:0] rsp0_dout_d, rsp1_dout_d;
  logic         busy_d;

  // Grant: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant_c = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_c = ~last_grant_q;
    end
    req0_ready = (state_q == IDLE) && !grant_c;
    req1_ready = (state_q == IDLE) && grant_c;
    accept_c   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    ram_we_d     = 1'b0;
    ram_adr_d    = ram_adr;
    ram_din_d    = ram_din;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp0_dout_d  = rsp0_dout;
    rsp1_dout_d  = rsp1_dout;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          state_d      = ACCESS;
          owner_d      = grant_c;
          last_grant_d = grant_c;
          ram_we_d     = grant_c ? req1_we  : req0_we;
          ram_adr_d    = grant_c ? req1_adr : req0_adr;
          ram_din_d    = grant_c ? req1_din : req0_din;
        end
      end
      ACCESS: begin
        // ram_we still carries the command's write flag during ACCESS
        if (ram_we) begin
          state_d = RESP;
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_dout_d  = '0;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_dout_d  = '0;
          end
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        state_d = RESP;
        if (owner_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_dout_d  = ram_dout;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_dout_d  = ram_dout;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      ram_we       <= 1'b0;
      ram_adr      <= '0;
      ram_din      <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp0_dout    <= '0;
      rsp1_dout    <= '0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      ram_we       <= ram_we_d;
      ram_adr      <= ram_adr_d;
      ram_din      <= ram_din_d;
      rsp0_valid   <= rsp0_valid_d;
      rsp1_valid   <= rsp1_valid_d;
      rsp0_dout    <= rsp0_dout_d;
      rsp1_dout    <= rsp1_dout_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: synchronous RAM harness, transaction-level reference
// model (memory array + round-robin + fixed latencies), directed and random traffic.
module tb_ram_arbiter;
  localparam int unsigned N = 4;
  localparam int unsigned M = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready, req0_we;
  logic [N-1:0] req0_adr;
  logic [M-1:0] req0_din;
  logic         rsp0_valid;
  logic [M-1:0] rsp0_dout;
  logic         req1_valid, req1_ready, req1_we;
  logic [N-1:0] req1_adr;
  logic [M-1:0] req1_din;
  logic         rsp1_valid;
  logic [M-1:0] rsp1_dout;
  logic         ram_we;
  logic [N-1:0] ram_adr;
  logic [M-1:0] ram_din;
  logic [M-1:0] ram_dout;
  logic         busy;

  ram_arbiter #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_adr(req0_adr), .req0_din(req0_din),
    .rsp0_valid(rsp0_valid), .rsp0_dout(rsp0_dout),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_adr(req1_adr), .req1_din(req1_din),
    .rsp1_valid(rsp1_valid), .rsp1_dout(rsp1_dout),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port RAM standing in for ram_top.
  logic [M-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_adr] <= ram_din;
    ram_dout <= ram_mem[ram_adr];
  end

  typedef struct packed {
    logic         we;
    logic [N-1:0] adr;
    logic [M-1:0] din;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [M-1:0] got, input logic [M-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", tag, got, exp);
  endtask

  // Reference model state
  logic [M-1:0] ref_mem [16];
  int           cyc = 0;
  bit           mon_en = 0;
  int           free_cyc, acc_cyc, rsp_cyc;
  bit           m_last, rsp_id, p_we;
  logic [N-1:0] p_adr;
  logic [M-1:0] p_din, rsp_data;
  bit           obs_acc0, obs_acc1;
  int           grants[$];
  int           acc_cycles[$];
  logic [M-1:0] last_rsp0, last_rsp1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic model_reset();
    free_cyc = cyc;
    acc_cyc  = -10;
    rsp_cyc  = -10;
    m_last   = 1'b1;
    obs_acc0 = 1'b0;
    obs_acc1 = 1'b0;
  endtask

  // Per-cycle check against the model; accepts are predicted, not read back.
  always @(negedge clk) begin : mon
    bit   idle;
    int   g;
    cmd_t c;
    if (mon_en) begin
      idle = (cyc >= free_cyc);
      g = -1;
      if (idle && (req0_valid || req1_valid))
        g = (req0_valid && req1_valid) ? (m_last ? 0 : 1) : (req0_valid ? 0 : 1);
      check("busy", M'(busy), M'(!idle));
      if (!idle || req0_valid) check("req0_ready", M'(req0_ready), M'(g == 0));
      if (!idle || req1_valid) check("req1_ready", M'(req1_ready), M'(g == 1));
      check("rsp0_valid", M'(rsp0_valid), M'(cyc == rsp_cyc && rsp_id == 1'b0));
      check("rsp1_valid", M'(rsp1_valid), M'(cyc == rsp_cyc && rsp_id == 1'b1));
      if (cyc == rsp_cyc) begin
        if (rsp_id) check("rsp1_dout", rsp1_dout, rsp_data);
        else        check("rsp0_dout", rsp0_dout, rsp_data);
      end
      check("ram_we", M'(ram_we), M'(cyc == acc_cyc + 1 && p_we));
      if (cyc == acc_cyc + 1) begin
        check("ram_adr", M'(ram_adr), M'(p_adr));
        if (p_we) check("ram_din", ram_din, p_din);
      end
      if (rsp0_valid) last_rsp0 = rsp0_dout;
      if (rsp1_valid) last_rsp1 = rsp1_dout;
      obs_acc0 = req0_valid && req0_ready;
      obs_acc1 = req1_valid && req1_ready;
      if (g >= 0) begin
        c.we  = (g == 1) ? req1_we  : req0_we;
        c.adr = (g == 1) ? req1_adr : req0_adr;
        c.din = (g == 1) ? req1_din : req0_din;
        m_last = (g == 1);
        grants.push_back(g);
        acc_cycles.push_back(cyc);
        acc_cyc = cyc;
        p_we = c.we; p_adr = c.adr; p_din = c.din;
        rsp_id = (g == 1);
        if (c.we) begin
          ref_mem[c.adr] = c.din;
          rsp_data = '0;
          rsp_cyc  = cyc + 2;
          free_cyc = cyc + 3;
        end else begin
          rsp_data = ref_mem[c.adr];
          rsp_cyc  = cyc + 3;
          free_cyc = cyc + 4;
        end
      end
    end
  end

  // Present queued commands, holding each until its handshake.
  task automatic run_queues(input int gap);
    int budget = 3000;
    cmd_t c;
    while ((q0.size() > 0 || q1.size() > 0 || req0_valid || req1_valid || cyc <= free_cyc)
           && budget > 0) begin
      @(posedge clk); #1;
      if (obs_acc0) req0_valid = 1'b0;
      if (obs_acc1) req1_valid = 1'b0;
      if (!req0_valid && q0.size() > 0 && $urandom_range(gap, 0) == 0) begin
        c = q0.pop_front();
        req0_valid = 1'b1; req0_we = c.we; req0_adr = c.adr; req0_din = c.din;
      end
      if (!req1_valid && q1.size() > 0 && $urandom_range(gap, 0) == 0) begin
        c = q1.pop_front();
        req1_valid = 1'b1; req1_we = c.we; req1_adr = c.adr; req1_din = c.din;
      end
      budget--;
    end
    check("run_timeout", M'(budget == 0), M'(0));
  endtask

  // Issue one command and return #1 into its ACCESS cycle.
  task automatic issue_to_access(input bit port, input cmd_t c);
    int budget = 20;
    @(posedge clk); #1;
    if (port) begin req1_valid = 1; req1_we = c.we; req1_adr = c.adr; req1_din = c.din; end
    else      begin req0_valid = 1; req0_we = c.we; req0_adr = c.adr; req0_din = c.din; end
    do begin
      @(posedge clk); #1;
      budget--;
    end while (!(port ? obs_acc1 : obs_acc0) && budget > 0);
    check("accept_timeout", M'(budget == 0), M'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Assert reset mid-cycle, check immediate effect, release, check quiet IDLE.
  task automatic mid_reset();
    mon_en = 0;
    rst = 1'b1;
    #1;
    check("rst ram_we", M'(ram_we), M'(0));
    check("rst rsp0_valid", M'(rsp0_valid), M'(0));
    check("rst rsp1_valid", M'(rsp1_valid), M'(0));
    check("rst busy", M'(busy), M'(0));
    check("rst ram_adr", M'(ram_adr), M'(0));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post-rst rsp0", M'(rsp0_valid), M'(0));
      check("post-rst rsp1", M'(rsp1_valid), M'(0));
      check("post-rst busy", M'(busy), M'(0));
    end
    model_reset();
    mon_en = 1;
  endtask

  initial begin
    cmd_t c;
    logic [M-1:0] saved;
    for (int i = 0; i < 16; i++) begin ram_mem[i] = '0; ref_mem[i] = '0; end
    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_adr = '0; req0_din = '0;
    req1_valid = 0; req1_we = 0; req1_adr = '0; req1_din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ram_we", M'(ram_we), M'(0));
    check("reset ram_adr", M'(ram_adr), M'(0));
    check("reset ram_din", ram_din, M'(0));
    check("reset rsp0", M'(rsp0_valid), M'(0));
    check("reset rsp1", M'(rsp1_valid), M'(0));
    check("reset dout0", rsp0_dout, M'(0));
    check("reset dout1", rsp1_dout, M'(0));
    check("reset busy", M'(busy), M'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1;

    // Contention: grants alternate starting with requester 0
    grants.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{we: 1'b1, adr: 4'h0, din: 32'h0000FFFF});
      q1.push_back('{we: 1'b1, adr: 4'h8, din: 32'hFFFFFFFF});
    end
    run_queues(0);
    check("grant count", M'(grants.size()), M'(8));
    for (int i = 0; i < grants.size(); i++) check("grant order", M'(grants[i]), M'(i % 2));
    q1.push_back('{we: 1'b0, adr: 4'h0, din: '0});
    q0.push_back('{we: 1'b0, adr: 4'h8, din: '0});
    run_queues(0);
    check("readback adr0", last_rsp1, 32'h0000FFFF);
    check("readback adr8", last_rsp0, 32'hFFFFFFFF);

    // Port 0 write then read of the same address
    q0.push_back('{we: 1'b1, adr: 4'h1, din: 32'h0000000A});
    q0.push_back('{we: 1'b0, adr: 4'h1, din: 32'h12345678});
    run_queues(0);
    check("p0 rd adr1", last_rsp0, 32'h0000000A);

    // Port 1 writes top address, port 0 reads it
    q1.push_back('{we: 1'b1, adr: 4'hF, din: 32'h0000FA12});
    run_queues(0);
    q0.push_back('{we: 1'b0, adr: 4'hF, din: '0});
    run_queues(0);
    check("p0 rd adrF", last_rsp0, 32'h0000FA12);

    // Back-to-back reads from port 0: one accept per 4 cycles
    acc_cycles.delete();
    for (int i = 0; i < 4; i++) q0.push_back('{we: 1'b0, adr: 4'(i), din: '0});
    run_queues(0);
    for (int i = 1; i < acc_cycles.size(); i++)
      check("rd spacing", M'(acc_cycles[i] - acc_cycles[i-1]), M'(4));

    // Cross-requester write-then-read in both directions
    q0.push_back('{we: 1'b1, adr: 4'h5, din: 32'h12345678});
    run_queues(0);
    q1.push_back('{we: 1'b0, adr: 4'h5, din: '0});
    run_queues(0);
    check("p1 rd adr5", last_rsp1, 32'h12345678);
    q1.push_back('{we: 1'b1, adr: 4'h6, din: 32'hCAFEF00D});
    run_queues(0);
    q0.push_back('{we: 1'b0, adr: 4'h6, din: '0});
    run_queues(0);
    check("p0 rd adr6", last_rsp0, 32'hCAFEF00D);

    // Reset during ACCESS of a write: write is dropped
    saved = ref_mem[2];
    issue_to_access(1'b1, '{we: 1'b1, adr: 4'h2, din: 32'h00000055});
    check("we in ACCESS", M'(ram_we), M'(1));
    mid_reset();
    ref_mem[2] = saved;

    // Reset during ACCESS of a read after a completed write
    q0.push_back('{we: 1'b1, adr: 4'h1, din: 32'h0000000F});
    run_queues(0);
    issue_to_access(1'b0, '{we: 1'b0, adr: 4'h1, din: '0});
    mid_reset();
    last_rsp0 = '1;
    last_rsp1 = '1;
    q0.push_back('{we: 1'b0, adr: 4'h1, din: '0});
    q1.push_back('{we: 1'b0, adr: 4'h2, din: '0});
    run_queues(0);
    check("re-read adr1", last_rsp0, 32'h0000000F);
    check("dropped write adr2", last_rsp1, saved);

    // Random traffic from both requesters with idle gaps
    for (int i = 0; i < 60; i++) begin
      c.we  = 1'($urandom_range(1, 0));
      c.adr = 4'($urandom_range(15, 0));
      c.din = $urandom;
      if ($urandom_range(1, 0) == 1) q1.push_back(c);
      else                           q0.push_back(c);
    end
    run_queues(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

endmodule
